rtc_bus_controller: RTL
=======================

# rtc_bus_controller

Bus-cycle engine between the PicoBlaze port decoder and the external RTC chip's multiplexed address/data bus. It takes one read or write request (address, data) from the controller side. It then generates the complete two-phase bus cycle on AD, CS, WR, RD and the bidirectional dato bus: address phase first, then data phase. It returns read data and a one-cycle completion pulse, which the port decoder exposes to software as fin_lectura_escritura.

## Interface
- T_SETUP, 2, clk cycles the bus value is driven before the CS/strobe low pulse (≥1)
- T_PULSE, 10, clk cycles CS and WR/RD are held low (≥1)
- T_HOLD, 2, clk cycles the bus value is held after the strobe rises (≥1)
- T_GAP, 10, clk cycles of idle bus between the address phase and the data phase (≥1)
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-low reset
- start_write  input  1  single-cycle request: write data_wr to register address
- start_read  input  1  single-cycle request: read register address into data_rd
- address  input  8  RTC register address; sampled on request acceptance
- data_wr  input  8  write data; sampled on request acceptance
- data_rd  output  8  last read value; updated only when a read completes
- busy  output  1  high from the cycle after acceptance through the done cycle
- done  output  1  one-cycle pulse when the cycle completes (read or write)
- dato  inout  8  RTC multiplexed address/data bus
- AD  output  1  0 = address phase, 1 = data phase or idle
- CS  output  1  chip select, active-low
- WR  output  1  write strobe, active-low
- RD  output  1  read strobe, active-low

## Operation
- All bus outputs are registered and decoded from the state register only. There are no combinational glitches on AD, CS, WR or RD.
- States: IDLE, A_SETUP, A_PULSE, A_HOLD, GAP, D_SETUP, D_PULSE, D_HOLD, DONE. A single 8-bit down-counter times each state.
- IDLE: AD=CS=WR=RD=1, dato=Z, busy=0.
  - On start_write or start_read: latch address, data_wr and op, then go to A_SETUP.
  - If both starts are high together, the write wins.
- A_SETUP (T_SETUP cycles): AD=0, dato=address, CS/WR high.
- A_PULSE (T_PULSE cycles): AD=0, CS=0, WR=0, dato=address.
- A_HOLD (T_HOLD cycles): AD=0, CS/WR high, dato=address.
- GAP (T_GAP cycles): AD=1, all strobes high, dato=Z.
- D_SETUP (T_SETUP cycles): AD=1, strobes high. dato=data_wr for a write, Z for a read.
- D_PULSE (T_PULSE cycles): CS=0, plus WR=0 (write) or RD=0 (read).
  - dato is driven only for a write.
  - For a read, dato is captured into data_rd at the clock edge that ends the last D_PULSE cycle.
- D_HOLD (T_HOLD cycles): strobes high. For a write, dato stays driven; for a read, dato=Z.
- DONE (1 cycle): done=1, busy=1, bus idle, then return to IDLE.
- RD and WR are never low in the same cycle. dato is never driven while RD=0.
- Requests arriving while busy=1 are ignored, not queued.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, AD=CS=WR=RD=1, dato=Z, data_rd=0x00, busy=0, done=0.
- Reset mid-cycle aborts the transaction. No done pulse is issued and data_rd is cleared.
- Request sampled at clock edge k:
  - A_SETUP outputs appear after edge k.
  - done is high in cycle k+1+2·(T_SETUP+T_PULSE+T_HOLD)+T_GAP.
  - With defaults, done occurs 39 cycles after the accepting edge (390 ns).
- The earliest next request is accepted in the cycle after done (back-to-back throughput, defaults: 40 cycles per transaction).
- data_rd changes exactly once per read, on the D_PULSE-ending edge, which is T_HOLD+1 cycles before done. It is stable by the time done is high.
- The counter loads value−1 on state entry. The state exits when the counter is 0 at an edge. Parameters of 1 give single-cycle states.

## Test plan
- Reset: hold reset=0 → AD=CS=WR=RD=1, dato=Z, data_rd=0x00, busy=0. Release reset → all outputs unchanged, no done pulse.
- Write: start_write with address=0x21, data_wr=0x45 (defaults) →
  - dato=0x21 with AD=0 and CS=WR=0 for exactly 10 cycles;
  - 10 cycles of Z with AD=1;
  - dato=0x45 with CS=WR=0 for 10 cycles;
  - RD stays 1 throughout;
  - done pulses once at 39 cycles.
- Read: start_read with address=0x22; bench model drives dato=0x59 while RD=0 →
  - address phase shows 0x22;
  - dato is Z from GAP onward and never driven while RD=0;
  - data_rd=0x59 when done pulses;
  - WR stays 1.
- Collision/overlap: start_write and start_read high in the same cycle → a write cycle is generated. A further start_read pulsed mid-transaction → ignored, with exactly one done pulse.
- Reset during D_PULSE of a read → immediately AD=CS=WR=RD=1, dato=Z, data_rd=0x00, no done. A new write after release completes normally.
- Parameters T_SETUP=T_PULSE=T_HOLD=T_GAP=1 → every state lasts 1 cycle and done occurs 8 cycles after the accepting edge. A back-to-back read then write is accepted in the cycle after the first done.

Source files
------------

// File: rtl/rtc_bus_controller.sv
// Two-phase (address, then data) bus-cycle engine for an RTC chip with a
// multiplexed AD bus; every bus pin comes straight from a flop.
module rtc_bus_controller #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 10,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_GAP   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_write,
    input  logic       start_read,
    input  logic [7:0] address,
    input  logic [7:0] data_wr,
    output logic [7:0] data_rd,
    output logic       busy,
    output logic       done,
    inout  wire  [7:0] dato,
    output logic       AD,
    output logic       CS,
    output logic       WR,
    output logic       RD
);

    typedef enum logic [3:0] {
        S_IDLE, S_A_SETUP, S_A_PULSE, S_A_HOLD, S_GAP,
        S_D_SETUP, S_D_PULSE, S_D_HOLD, S_DONE
    } state_e;

    localparam logic [7:0] LD_SETUP = 8'(T_SETUP - 1);
    localparam logic [7:0] LD_PULSE = 8'(T_PULSE - 1);
    localparam logic [7:0] LD_HOLD  = 8'(T_HOLD - 1);
    localparam logic [7:0] LD_GAP   = 8'(T_GAP - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       wr_op_q, wr_op_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ad_q, ad_d, cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
    logic       oe_q, oe_d, busy_q, busy_d, done_q, done_d;
    logic [7:0] dout_q, dout_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_op_d = wr_op_q;
        rdata_d = rdata_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 8'd1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_write || start_read) begin
                        addr_d  = address;
                        wdata_d = data_wr;
                        wr_op_d = start_write;
                        state_d = S_A_SETUP;
                        cnt_d   = LD_SETUP;
                    end
                end
                S_A_SETUP: begin state_d = S_A_PULSE; cnt_d = LD_PULSE; end
                S_A_PULSE: begin state_d = S_A_HOLD;  cnt_d = LD_HOLD;  end
                S_A_HOLD:  begin state_d = S_GAP;     cnt_d = LD_GAP;   end
                S_GAP:     begin state_d = S_D_SETUP; cnt_d = LD_SETUP; end
                S_D_SETUP: begin state_d = S_D_PULSE; cnt_d = LD_PULSE; end
                S_D_PULSE: begin state_d = S_D_HOLD;  cnt_d = LD_HOLD;  end
                S_D_HOLD:  begin state_d = S_DONE;    cnt_d = '0;       end
                S_DONE:    begin state_d = S_IDLE;    cnt_d = '0;       end
                default:   begin state_d = S_IDLE;    cnt_d = '0;       end
            endcase
        end
        // Read data is sampled on the edge that closes the last strobe cycle
        if (state_q == S_D_PULSE && cnt_q == '0 && !wr_op_q) begin
            rdata_d = dato;
        end
    end

    // Pin values are decoded from the next state so they update together with it
    always_comb begin
        ad_d   = 1'b1;
        cs_d   = 1'b1;
        wr_d   = 1'b1;
        rd_d   = 1'b1;
        oe_d   = 1'b0;
        dout_d = '0;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        unique case (state_d)
            S_A_SETUP, S_A_HOLD: begin
                ad_d   = 1'b0;
                oe_d   = 1'b1;
                dout_d = addr_d;
            end
            S_A_PULSE: begin
                ad_d   = 1'b0;
                cs_d   = 1'b0;
                wr_d   = 1'b0;
                oe_d   = 1'b1;
                dout_d = addr_d;
            end
            S_D_SETUP, S_D_HOLD: begin
                oe_d   = wr_op_d;
                dout_d = wdata_d;
            end
            S_D_PULSE: begin
                cs_d   = 1'b0;
                wr_d   = !wr_op_d;
                rd_d   = wr_op_d;
                oe_d   = wr_op_d;
                dout_d = wdata_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_op_q <= 1'b0;
            rdata_q <= '0;
            ad_q    <= 1'b1;
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            rd_q    <= 1'b1;
            oe_q    <= 1'b0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_op_q <= wr_op_d;
            rdata_q <= rdata_d;
            ad_q    <= ad_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            oe_q    <= oe_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dato    = oe_q ? dout_q : 'z;
    assign data_rd = rdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign AD      = ad_q;
    assign CS      = cs_q;
    assign WR      = wr_q;
    assign RD      = rd_q;

endmodule
